// File: rtl/ic_clock_stepper_pkg.sv
// Shared constants for the clock stepper: FSM state encoding and pulse counter width.
package ic_clock_stepper_pkg;

   localparam int unsigned PULSE_CNT_W = 8;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_STEP_HI = 2'd1;
   localparam logic [1:0] ST_RUN_HI  = 2'd2;
   localparam logic [1:0] ST_RUN_LO  = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      STEP_HI = ST_STEP_HI,
      RUN_HI  = ST_RUN_HI,
      RUN_LO  = ST_RUN_LO
   } state_e;

   function automatic logic is_high(input state_e s);
      return (s == STEP_HI) || (s == RUN_HI);
   endfunction

endpackage

// File: rtl/ic_clock_stepper_if.sv
// Control inputs and clock-wave outputs of the clock stepper.
interface ic_clock_stepper_if #(
   parameter int unsigned DIV_WIDTH = 24
);
   import ic_clock_stepper_pkg::*;

   logic                   MODE;
   logic                   STEP_BTN;
   logic                   RUN_EN;
   logic [DIV_WIDTH-1:0]   DIV;
   logic                   CKA_OUT;
   logic                   CK_FALL;
   logic [PULSE_CNT_W-1:0] PULSE_CNT;

   modport master (
      output MODE, STEP_BTN, RUN_EN, DIV,
      input  CKA_OUT, CK_FALL, PULSE_CNT
   );

   modport slave (
      input  MODE, STEP_BTN, RUN_EN, DIV,
      output CKA_OUT, CK_FALL, PULSE_CNT
   );
endinterface

// File: rtl/ic_debounce.sv
// Synchronizes a bouncy button, accepts a level only after DEBOUNCE_CYCLES stable
// cycles, and emits a one-cycle pulse on each accepted rising edge.
module ic_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_press
);
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

   logic             r_s1;
   logic             r_s2;
   logic             r_level;
   logic             r_level_d;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_s1      <= i_raw;
         r_s2      <= r_s1;
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
         // Any return to the accepted level restarts the stability window
         if (r_s2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_s2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/ic_clock_stepper.sv
// Glitch-free slow clock source for the LS93 CKA input: single-step per button press
// or free-running at 2*DIV_eff cycles per period, with falling-edge flag and count.
module ic_clock_stepper
   import ic_clock_stepper_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned DIV_WIDTH       = 24
) (
   input  logic         CLK,
   input  logic         CLR_N,
   ic_clock_stepper_if.slave bus
);

   state_e                 r_state;
   state_e                 w_state_nxt;
   logic                   r_mode_s1;
   logic                   r_mode_s2;
   logic                   r_cka;
   logic                   r_fall;
   logic                   w_cka_nxt;
   logic                   w_fall_nxt;
   logic                   w_press;
   logic                   w_run_ok;
   logic                   w_done;
   logic [DIV_WIDTH-1:0]   r_cnt;
   logic [DIV_WIDTH-1:0]   w_cnt_nxt;
   logic [DIV_WIDTH-1:0]   w_div_eff;
   logic [DIV_WIDTH-1:0]   w_load;
   logic [PULSE_CNT_W-1:0] r_pulse_cnt;

   ic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
      .clk     (CLK),
      .rst_n   (CLR_N),
      .i_raw   (bus.STEP_BTN),
      .o_press (w_press)
   );

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_mode_s1 <= 1'b0;
         r_mode_s2 <= 1'b0;
      end else begin
         r_mode_s1 <= bus.MODE;
         r_mode_s2 <= r_mode_s1;
      end
   end

   // Phase counter loads DIV_eff-1 at each phase start; phase ends when it reaches 0
   assign w_div_eff = (bus.DIV == '0) ? DIV_WIDTH'(1) : bus.DIV;
   assign w_load    = w_div_eff - DIV_WIDTH'(1);
   assign w_run_ok  = r_mode_s2 & bus.RUN_EN;
   assign w_done    = (r_cnt == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fall_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            // Free-run request takes priority over a coincident press
            if (w_run_ok) begin
               w_state_nxt = RUN_HI;
               w_cnt_nxt   = w_load;
            end else if (!r_mode_s2 && w_press) begin
               w_state_nxt = STEP_HI;
               w_cnt_nxt   = w_load;
            end
         end
         STEP_HI: begin
            if (w_done) begin
               w_state_nxt = IDLE;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
            end
         end
         RUN_HI: begin
            if (w_done) begin
               w_state_nxt = RUN_LO;
               w_cnt_nxt   = w_load;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
            end
         end
         RUN_LO: begin
            if (w_done) begin
               if (w_run_ok) begin
                  w_state_nxt = RUN_HI;
                  w_cnt_nxt   = w_load;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_cka_nxt = is_high(w_state_nxt);
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_cka       <= 1'b0;
         r_fall      <= 1'b0;
         r_pulse_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cka       <= w_cka_nxt;
         r_fall      <= w_fall_nxt;
         r_pulse_cnt <= r_pulse_cnt + PULSE_CNT_W'(r_fall);
      end
   end

   assign bus.CKA_OUT   = r_cka;
   assign bus.CK_FALL   = r_fall;
   assign bus.PULSE_CNT = r_pulse_cnt;

endmodule

// File: doc/ic_clock_stepper.md
# ic_clock_stepper

Clock-pulse source that drives the CKA input of the SN74LS93 counter stage in the emulator. The block derives a slow, glitch-free square wave from the board clock in one of two modes. In single-step mode it emits one pulse per debounced button press. In free-run mode it emits a continuous wave at a programmable rate. It also flags each falling edge, which is the LS93's active edge, and counts the edges so the bench can cross-check the counter's state.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000: CLK cycles the synchronized button must stay stable before a level change is accepted.
- DIV_WIDTH, 24: width of the DIV input.

Ports:
- CLK  in  1  board clock; the only clock in the block.
- CLR_N  in  1  asynchronous, active-low reset.
- MODE  in  1  raw switch input; 0 = single-step, 1 = free-run. Asynchronous to CLK.
- STEP_BTN  in  1  raw push-button input, active-high. Asynchronous to CLK and bouncy.
- RUN_EN  in  1  free-run gate, synchronous to CLK.
- DIV  in  DIV_WIDTH  phase length in CLK cycles, applied to each high and each low phase. A value of 0 is treated as 1.
- CKA_OUT  out  1  registered clock wave, to the counter's CKA input.
- CK_FALL  out  1  one-CLK pulse, asserted in the same cycle CKA_OUT goes 1→0.
- PULSE_CNT  out  8  count of falling edges produced; wraps from 255 to 0.

## Operation
- Input conditioning: MODE and STEP_BTN each pass through a 2-FF synchronizer. STEP_BTN is then debounced: a level change is accepted only after DEBOUNCE_CYCLES consecutive cycles of the new level. A press is the rising edge of the debounced level.
- Divisor handling: DIV_eff = (DIV == 0) ? 1 : DIV. DIV_eff is sampled at the start of every phase and held for that phase.
- States:
  - IDLE: CKA_OUT = 0.
  - STEP_HI: CKA_OUT = 1.
  - RUN_HI: CKA_OUT = 1.
  - RUN_LO: CKA_OUT = 0.
- Transitions:
  - IDLE → RUN_HI when synchronized MODE = 1 and RUN_EN = 1.
  - IDLE → STEP_HI on a press while synchronized MODE = 0.
  - STEP_HI → IDLE after DIV_eff cycles. CKA_OUT falls, CK_FALL pulses.
  - RUN_HI → RUN_LO after DIV_eff cycles. CKA_OUT falls, CK_FALL pulses.
  - RUN_LO → RUN_HI after DIV_eff cycles if MODE = 1 and RUN_EN = 1; otherwise RUN_LO → IDLE.
- Presses are ignored outside IDLE and are never queued. This includes presses during a STEP_HI pulse and presses in free-run mode.
- Changes to MODE or RUN_EN take effect only at a phase boundary. A high phase always completes its full DIV_eff cycles, so no runt pulses are produced.
- PULSE_CNT increments by 1 in the cycle CK_FALL is asserted.

## Timing
- Reset (CLR_N = 0, asynchronous): the following clear immediately and hold until reset is released:
  - CKA_OUT = 0, CK_FALL = 0, PULSE_CNT = 0
  - state = IDLE
  - synchronizers, debounced level and debounce counter = 0
  - phase counter = 0
- Reset mid-pulse drops CKA_OUT without asserting CK_FALL and without incrementing PULSE_CNT.
- Press-to-rise latency: CKA_OUT rises 2 (sync) + DEBOUNCE_CYCLES + 1 (edge detect) + 1 (state register) CLK cycles after a clean STEP_BTN rise.
- Free-run period: 2·DIV_eff cycles at 50 % duty. The first rise comes 1 cycle after the IDLE → RUN_HI condition is seen.
- CK_FALL and the CKA_OUT 1→0 transition are registered in the same edge. PULSE_CNT shows its new value in the following cycle.
- Simultaneous events:
  - A press in the same cycle MODE goes 0→1: MODE wins and the press is discarded.
  - RUN_EN dropping during RUN_HI: the high phase completes, then the low phase completes, then the block enters IDLE.

## Structure
- Shared package ic_clock_stepper_pkg holds the state encoding as localparams (IDLE, STEP_HI, RUN_HI, RUN_LO) and the PULSE_CNT width constant.
- One sub-module, ic_debounce: 2-FF synchronizer, stability counter and rising-edge detector, parameterized by DEBOUNCE_CYCLES. Instantiated once, for STEP_BTN.
- MODE uses a bare 2-FF synchronizer in the top level.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 unless noted.
- Reset: assert CLR_N = 0 during RUN_HI with DIV = 5 → CKA_OUT and PULSE_CNT are 0 within the same timestep, and no CK_FALL occurs.
- Single step: MODE = 0, DIV = 3, clean press held for 10 cycles → exactly one CKA_OUT high of 3 cycles, beginning 8 cycles after the press. One CK_FALL, PULSE_CNT = 1.
- Bounce: STEP_BTN toggles every 2 cycles for 20 cycles, then holds high → no pulse during toggling, exactly one pulse after the stable hold, PULSE_CNT = 1.
- Free-run: MODE = 1, RUN_EN = 1, DIV = 2 → period of 4 cycles. Over 40 cycles after the first rise, 10 CK_FALL pulses and PULSE_CNT = 10. DIV = 0 → period of 2 cycles.
- Mode switch: MODE goes 1→0 one cycle into RUN_HI with DIV = 4 → the high phase lasts the full 4 cycles, then the low phase lasts 4 cycles, then IDLE with CKA_OUT = 0. A press during those 8 cycles is ignored.
- Wrap: 256 free-run edges from reset → PULSE_CNT returns to 0 on the 256th CK_FALL.
